lut_vector_sequencer: RTL and testbench
=======================================

// Module: lut_vector_sequencer
// PURPOSE
//  Sequences the vectoring-mode coefficient LUT for the high-radix CORDIC.
//  Per iteration: takes an address from digit selection, pulses the LUT enable,
//  waits for LUT done, registers kappa/theta/delta and hands them to the datapath
//  over a valid/ready handshake. Counts iterations, then reports completion.
// PARAMETERS
//  NUM_ITER  8   iterations per vectoring operation (1..255)
//  TIMEOUT   4   cycles to wait for lut_done before flagging error (>=2)
//  DW        32  kappa/theta/delta word width
// PORTS
//  clock        in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  start        in   1   begin operation; sampled in IDLE only
//  mode         in   2   01 circular, 11 hyperbolic; latched at start
//  addr_valid   in   1   digit-select address available
//  addr         in   8   LUT address for the current iteration
//  addr_ready   out  1   address accepted this cycle (addr_valid & addr_ready)
//  lut_mode     out  2   latched mode to LUT
//  lut_address  out  8   registered address to LUT
//  lut_enable   out  1   one-cycle lookup request to LUT
//  lut_operation out 1   held 0 (vectoring select)
//  lut_done     in   1   LUT data valid
//  lut_kappa/lut_theta/lut_delta in DW  LUT outputs
//  coef_valid   out  1   registered coefficients valid
//  coef_ready   in   1   datapath consumed coefficients
//  kappa/theta/delta out DW  registered coefficients
//  iter         out  8   current iteration index (0..NUM_ITER-1)
//  busy         out  1   state != IDLE
//  finished     out  1   one-cycle pulse after last coefficient accepted
//  error        out  1   sticky until next accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including lut_operation, iter, kappa/theta/delta.
//  States:
//   IDLE: start & mode in {01,11} -> latch mode, iter=0, error=0 -> WAIT_ADDR.
//         start & mode in {00,10} -> error=1, no lookup, stay IDLE.
//   WAIT_ADDR: addr_ready=1; on addr_valid -> lut_address<=addr -> ISSUE.
//   ISSUE: lut_enable=1 for exactly one cycle; timer cleared -> WAIT_DONE.
//   WAIT_DONE: on lut_done -> capture lut_kappa/theta/delta -> HOLD.
//              No lut_done within TIMEOUT cycles -> error=1 -> IDLE.
//   HOLD: coef_valid=1; coefficients stable; on coef_ready ->
//         iter==NUM_ITER-1 ? FINISH : (iter++ , WAIT_ADDR).
//   FINISH: finished=1 one cycle -> IDLE.
//  Timing: address accept to lut_enable is 1 cycle; LUT returns done 1 cycle
//   after enable; best case address to coef_valid is 3 cycles.
//  start while busy is ignored; mode changes after start are ignored.
//  addr_ready and coef_valid are never high together.
//  lut_done outside WAIT_DONE is ignored.
//  Coefficient regs keep their last value in IDLE.
//  coef_ready without coef_valid has no effect.
//  reset_n low at any point: immediate return to IDLE and reset values;
//   no finished pulse; error is cleared.
//  iter stays at NUM_ITER-1 through FINISH and is cleared at the next start.
// STRUCTURE
//  Shared package cordic_pkg: state encoding localparams (IDLE, WAIT_ADDR,
//   ISSUE, WAIT_DONE, HOLD, FINISH), MODE_CIRC=2'b01, MODE_HYPER=2'b11, OP_VECTOR=1'b0.
//  Single always block FSM plus datapath registers; timeout counter inline.
//  Optional sub-module: coef_hold_reg (DW*3 capture register with valid/ready).
// TESTING
//  1 mode=01, NUM_ITER=8, addr 0..7, coef_ready=1, LUT model -> 8 lut_enable pulses,
//    kappa/theta/delta match LUT entries, finished pulse, iter=7.
//  2 mode=00 start -> error=1, no lut_enable, busy stays 0; then mode=11 start clears error.
//  3 LUT model never asserts done -> error after TIMEOUT=4 cycles, state IDLE, no coef_valid.
//  4 coef_ready low 5 cycles in HOLD -> coef_valid held, outputs stable, addr_ready=0.
//  5 reset_n low in WAIT_DONE at iter=3 -> busy=0, outputs 0 asynchronously, no finished.
//  6 start pulsed mid-operation with mode=00 -> ignored, no error, sequence completes.

Source files
------------

// File: rtl/lut_vector_sequencer_pkg.sv
// Shared types and constants for the vectoring-mode CORDIC coefficient LUT sequencer.
package lut_vector_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitAddr,
    StIssue,
    StWaitDone,
    StHold,
    StFinish
  } state_e;

  localparam logic [1:0] MODE_CIRC  = 2'b01;
  localparam logic [1:0] MODE_HYPER = 2'b11;
  localparam logic       OP_VECTOR  = 1'b0;

  function automatic logic mode_valid(input logic [1:0] m);
    return (m == MODE_CIRC) || (m == MODE_HYPER);
  endfunction

endpackage

// File: rtl/lut_vector_sequencer_if.sv
// Bundles control, digit-select address, LUT and coefficient handshakes of the sequencer.
interface lut_vector_sequencer_if #(
  parameter int unsigned DW = 32
);
  logic          start;
  logic [1:0]    mode;
  logic          addr_valid;
  logic [7:0]    addr;
  logic          addr_ready;
  logic [1:0]    lut_mode;
  logic [7:0]    lut_address;
  logic          lut_enable;
  logic          lut_operation;
  logic          lut_done;
  logic [DW-1:0] lut_kappa;
  logic [DW-1:0] lut_theta;
  logic [DW-1:0] lut_delta;
  logic          coef_valid;
  logic          coef_ready;
  logic [DW-1:0] kappa;
  logic [DW-1:0] theta;
  logic [DW-1:0] delta;
  logic [7:0]    iter;
  logic          busy;
  logic          finished;
  logic          error;

  modport slave (
    input  start, mode, addr_valid, addr, lut_done, lut_kappa, lut_theta, lut_delta,
           coef_ready,
    output addr_ready, lut_mode, lut_address, lut_enable, lut_operation, coef_valid,
           kappa, theta, delta, iter, busy, finished, error
  );

  modport master (
    output start, mode, addr_valid, addr, lut_done, lut_kappa, lut_theta, lut_delta,
           coef_ready,
    input  addr_ready, lut_mode, lut_address, lut_enable, lut_operation, coef_valid,
           kappa, theta, delta, iter, busy, finished, error
  );

endinterface

// File: rtl/lut_vector_sequencer_coef_hold.sv
// Capture register for the kappa/theta/delta triple; holds its value until the next load.
module lut_vector_sequencer_coef_hold #(
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] lut_kappa,
  input  logic [DW-1:0] lut_theta,
  input  logic [DW-1:0] lut_delta,
  output logic [DW-1:0] kappa,
  output logic [DW-1:0] theta,
  output logic [DW-1:0] delta
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kappa <= '0;
      theta <= '0;
      delta <= '0;
    end else if (load) begin
      kappa <= lut_kappa;
      theta <= lut_theta;
      delta <= lut_delta;
    end
  end

endmodule

// File: rtl/lut_vector_sequencer.sv
// Per-iteration coefficient LUT sequencer for vectoring-mode high-radix CORDIC:
// address in, one LUT lookup, coefficients out over valid/ready, NUM_ITER times.
module lut_vector_sequencer
  import lut_vector_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ITER = 8,
  parameter int unsigned TIMEOUT  = 4,
  parameter int unsigned DW       = 32
) (
  input logic                   clock,
  input logic                   reset_n,
  lut_vector_sequencer_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    iter_q;
  logic [1:0]    mode_q;
  logic [7:0]    addr_q;
  logic          error_q;
  logic          capture;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      iter_q  <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (mode_valid(bus.mode)) begin
              mode_q  <= bus.mode;
              iter_q  <= '0;
              error_q <= 1'b0;
              state_q <= StWaitAddr;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StWaitAddr: begin
          if (bus.addr_valid) begin
            addr_q  <= bus.addr;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          // A done arriving on the last allowed cycle still wins over the timeout.
          if (bus.lut_done) begin
            state_q <= StHold;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StHold: begin
          if (bus.coef_ready) begin
            if (iter_q == 8'(NUM_ITER - 1)) begin
              state_q <= StFinish;
            end else begin
              iter_q  <= iter_q + 8'd1;
              state_q <= StWaitAddr;
            end
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign capture = (state_q == StWaitDone) && bus.lut_done;

  lut_vector_sequencer_coef_hold #(
    .DW(DW)
  ) u_coef_hold (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (capture),
    .lut_kappa(bus.lut_kappa),
    .lut_theta(bus.lut_theta),
    .lut_delta(bus.lut_delta),
    .kappa    (bus.kappa),
    .theta    (bus.theta),
    .delta    (bus.delta)
  );

  // Handshake strobes are pure decodes of the state register, so they are glitch-free
  // and addr_ready/coef_valid can never overlap.
  assign bus.addr_ready    = (state_q == StWaitAddr);
  assign bus.lut_enable    = (state_q == StIssue);
  assign bus.coef_valid    = (state_q == StHold);
  assign bus.finished      = (state_q == StFinish);
  assign bus.busy          = (state_q != StIdle);
  assign bus.lut_mode      = mode_q;
  assign bus.lut_address   = addr_q;
  assign bus.lut_operation = OP_VECTOR;
  assign bus.iter          = iter_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_lut_vector_sequencer.sv
// Self-checking bench for lut_vector_sequencer: randomized LUT contents and addresses
// against a table-based expectation of what each iteration must deliver.
module tb_lut_vector_sequencer;

  localparam int unsigned NUM_ITER = 8;
  localparam int unsigned TIMEOUT  = 4;
  localparam int unsigned DW       = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  lut_vector_sequencer_if #(.DW(DW)) bus ();

  lut_vector_sequencer #(
    .NUM_ITER(NUM_ITER),
    .TIMEOUT (TIMEOUT),
    .DW      (DW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] lut_k [256];
  logic [DW-1:0] lut_t [256];
  logic [DW-1:0] lut_d [256];
  bit            lut_silent = 1'b0;

  int enable_count  = 0;
  int finish_count  = 0;
  int overlap_count = 0;

  // LUT model: data valid one cycle after a lookup request.
  always @(posedge clock) begin
    bus.lut_done  <= bus.lut_enable && !lut_silent;
    bus.lut_kappa <= lut_k[bus.lut_address];
    bus.lut_theta <= lut_t[bus.lut_address];
    bus.lut_delta <= lut_d[bus.lut_address];
  end

  always @(posedge clock) begin
    if (reset_n) begin
      if (bus.lut_enable) enable_count <= enable_count + 1;
      if (bus.finished) finish_count <= finish_count + 1;
      if (bus.addr_ready && bus.coef_valid) overlap_count <= overlap_count + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [1:0] m);
    bus.start = 1'b1;
    bus.mode  = m;
    tick();
    bus.start = 1'b0;
  endtask

  // Presents one address and waits (bounded) for coef_valid; lat counts edges from drive.
  task automatic issue_addr(input logic [7:0] a, output bit got, output int lat);
    bus.addr_valid = 1'b1;
    bus.addr       = a;
    got            = 1'b0;
    tick();
    bus.addr_valid = 1'b0;
    lat            = 1;
    for (int i = 0; i < 12 && !got; i++) begin
      if (bus.coef_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
  endtask

  task automatic accept_coef();
    bus.coef_ready = 1'b1;
    tick();
    bus.coef_ready = 1'b0;
  endtask

  task automatic finish_op(input int from_iter);
    bit got;
    int lat;
    for (int i = from_iter; i < NUM_ITER; i++) begin
      issue_addr(8'($urandom_range(0, 255)), got, lat);
      if (!got) return;
      accept_coef();
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.busy, bus.addr_ready, bus.coef_valid, bus.lut_enable, bus.finished, bus.error,
         bus.lut_operation} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000", {bus.busy, bus.addr_ready,
               bus.coef_valid, bus.lut_enable, bus.finished, bus.error, bus.lut_operation});
    end
    n_checks++;
    if ({bus.iter, bus.lut_mode, bus.lut_address} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_regs: iter %h mode %b addr %h want 0", bus.iter, bus.lut_mode,
               bus.lut_address);
    end
    n_checks++;
    if ({bus.kappa, bus.theta, bus.delta} !== {3 * DW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_coef: got %h %h %h want 0", bus.kappa, bus.theta, bus.delta);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_circular();
    bit got;
    int lat;
    int e0 = enable_count;
    int f0 = finish_count;
    start_op(2'b01);
    n_checks++;
    if ({bus.busy, bus.addr_ready, bus.lut_mode, bus.iter} !== {1'b1, 1'b1, 2'b01, 8'd0}) begin
      n_fail++;
      $display("FAIL circ_start: busy %b ready %b mode %b iter %0d want 1 1 01 0", bus.busy,
               bus.addr_ready, bus.lut_mode, bus.iter);
    end
    for (int i = 0; i < NUM_ITER; i++) begin
      issue_addr(8'(i), got, lat);
      n_checks++;
      if (!got || lat != 3) begin
        n_fail++;
        $display("FAIL circ_latency[%0d]: valid %b after %0d edges want 1 after 3", i, got, lat);
      end
      n_checks++;
      if ({bus.kappa, bus.theta, bus.delta, bus.iter} !== {lut_k[i], lut_t[i], lut_d[i], 8'(i)})
      begin
        n_fail++;
        $display("FAIL circ_coef[%0d]: got %h %h %h iter %0d want %h %h %h iter %0d", i,
                 bus.kappa, bus.theta, bus.delta, bus.iter, lut_k[i], lut_t[i], lut_d[i], i);
      end
      accept_coef();
    end
    n_checks++;
    if ({bus.finished, bus.iter} !== {1'b1, 8'(NUM_ITER - 1)}) begin
      n_fail++;
      $display("FAIL circ_finish: finished %b iter %0d want 1 %0d", bus.finished, bus.iter,
               NUM_ITER - 1);
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || enable_count - e0 != NUM_ITER || finish_count - f0 != 1) begin
      n_fail++;
      $display("FAIL circ_counts: busy %b enables %0d finishes %0d want 0 %0d 1", bus.busy,
               enable_count - e0, finish_count - f0, NUM_ITER);
    end
    n_checks++;
    if ({bus.kappa, bus.iter} !== {lut_k[NUM_ITER - 1], 8'(NUM_ITER - 1)}) begin
      n_fail++;
      $display("FAIL circ_idle_hold: kappa %h iter %0d want %h %0d", bus.kappa, bus.iter,
               lut_k[NUM_ITER - 1], NUM_ITER - 1);
    end
  endtask

  task automatic test_bad_mode();
    logic [1:0] bad [2];
    int e0 = enable_count;
    int f0 = finish_count;
    bad[0] = 2'b00;
    bad[1] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      start_op(bad[k]);
      tick();
      n_checks++;
      if ({bus.error, bus.busy} !== 2'b10 || enable_count != e0) begin
        n_fail++;
        $display("FAIL bad_mode[%b]: error %b busy %b enables %0d want 1 0 0", bad[k],
                 bus.error, bus.busy, enable_count - e0);
      end
    end
    start_op(2'b11);
    n_checks++;
    if ({bus.error, bus.busy, bus.lut_mode} !== {1'b0, 1'b1, 2'b11}) begin
      n_fail++;
      $display("FAIL hyper_start: error %b busy %b mode %b want 0 1 11", bus.error, bus.busy,
               bus.lut_mode);
    end
    finish_op(0);
    n_checks++;
    if (finish_count - f0 != 1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hyper_done: finishes %0d busy %b want 1 0", finish_count - f0, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int  n         = 1;
    bit  seen      = 1'b0;
    start_op(2'b01);
    lut_silent     = 1'b1;
    bus.addr_valid = 1'b1;
    bus.addr       = 8'($urandom_range(0, 255));
    tick();
    bus.addr_valid = 1'b0;
    while (bus.busy && n < 20) begin
      if (bus.coef_valid) seen = 1'b1;
      tick();
      n++;
    end
    lut_silent = 1'b0;
    n_checks++;
    if (n != 2 + TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_cycles: idle after %0d edges want %0d", n, 2 + TIMEOUT);
    end
    n_checks++;
    if ({bus.error, bus.busy, seen} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_state: error %b busy %b saw_valid %b want 1 0 0", bus.error,
               bus.busy, seen);
    end
    tick();
    tick();
    n_checks++;
    if (bus.error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: error %b want 1", bus.error);
    end
  endtask

  task automatic test_backpressure();
    bit           got;
    int           lat;
    logic [7:0]   a = 8'($urandom_range(0, 255));
    logic [3*DW-1:0] exp_c;
    start_op(2'b11);
    issue_addr(a, got, lat);
    exp_c = {lut_k[a], lut_t[a], lut_d[a]};
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({bus.coef_valid, bus.addr_ready} !== 2'b10 ||
          {bus.kappa, bus.theta, bus.delta} !== exp_c || bus.iter !== 8'd0) begin
        n_fail++;
        $display("FAIL stall[%0d]: valid %b ready %b coef %h iter %0d want 1 0 %h 0", c,
                 bus.coef_valid, bus.addr_ready, {bus.kappa, bus.theta, bus.delta}, bus.iter,
                 exp_c);
      end
    end
    accept_coef();
    n_checks++;
    if ({bus.addr_ready, bus.coef_valid, bus.iter} !== {1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL stall_release: ready %b valid %b iter %0d want 1 0 1", bus.addr_ready,
               bus.coef_valid, bus.iter);
    end
    finish_op(1);
  endtask

  task automatic test_reset_mid();
    bit got;
    int lat;
    int f0;
    start_op(2'b01);
    for (int i = 0; i < 3; i++) begin
      issue_addr(8'($urandom_range(0, 255)), got, lat);
      accept_coef();
    end
    bus.addr_valid = 1'b1;
    bus.addr       = 8'($urandom_range(0, 255));
    tick();
    bus.addr_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.busy, bus.iter, bus.coef_valid} !== {1'b1, 8'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_reset: busy %b iter %0d valid %b want 1 3 0", bus.busy, bus.iter,
               bus.coef_valid);
    end
    f0 = finish_count;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.error, bus.coef_valid, bus.lut_enable, bus.iter, bus.lut_mode,
         bus.lut_address} !== 22'h0 || {bus.kappa, bus.theta, bus.delta} !== {3 * DW{1'b0}})
    begin
      n_fail++;
      $display("FAIL async_reset: busy %b iter %0d mode %b addr %h kappa %h want all 0",
               bus.busy, bus.iter, bus.lut_mode, bus.lut_address, bus.kappa);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (finish_count != f0 || bus.busy !== 1'b0 || bus.finished !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: finishes %0d busy %b want 0 0", finish_count - f0, bus.busy);
    end
  endtask

  task automatic test_start_ignored();
    bit got;
    int lat;
    int f0 = finish_count;
    start_op(2'b01);
    issue_addr(8'($urandom_range(0, 255)), got, lat);
    accept_coef();
    start_op(2'b00);
    n_checks++;
    if ({bus.error, bus.busy, bus.addr_ready, bus.lut_mode, bus.iter} !==
        {1'b0, 1'b1, 1'b1, 2'b01, 8'd1}) begin
      n_fail++;
      $display("FAIL start_busy_addr: error %b busy %b ready %b mode %b iter %0d want 0 1 1 01 1",
               bus.error, bus.busy, bus.addr_ready, bus.lut_mode, bus.iter);
    end
    issue_addr(8'($urandom_range(0, 255)), got, lat);
    start_op(2'b11);
    n_checks++;
    if ({bus.error, bus.coef_valid, bus.lut_mode} !== {1'b0, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL start_busy_hold: error %b valid %b mode %b want 0 1 01", bus.error,
               bus.coef_valid, bus.lut_mode);
    end
    accept_coef();
    finish_op(2);
    n_checks++;
    if (finish_count - f0 != 1 || {bus.busy, bus.error} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_busy_done: finishes %0d busy %b error %b want 1 0 0",
               finish_count - f0, bus.busy, bus.error);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.mode       = 2'b00;
    bus.addr_valid = 1'b0;
    bus.addr       = 8'h00;
    bus.coef_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      lut_k[i] = $urandom;
      lut_t[i] = $urandom;
      lut_d[i] = $urandom;
    end
    test_reset();
    test_circular();
    test_bad_mode();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    n_checks++;
    if (overlap_count != 0) begin
      n_fail++;
      $display("FAIL ready_valid_overlap: %0d cycles want 0", overlap_count);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
